// File: rtl/core_if_pkg.sv
// rtl/core_if_pkg.sv - shared types and constants for the core_if fetch stage
package core_if_pkg;

    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] CORE_NOP_INS  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_ERR     = 2'd2
    } if_state_t;

    // One prefetch entry: {err, pc, ins}, 65 bits.
    typedef struct packed {
        logic        err;
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/core_if_fifo.sv
// rtl/core_if_fifo.sv - prefetch FIFO with push, pop, flush, count, full and empty
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; wins over push and pop in the same cycle
//   rdata        : head entry (undefined when empty)
//   count        : number of stored entries
//   full, empty  : status flags
module core_if_fifo
    import core_if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/core_if.sv
// rtl/core_if.sv - instruction fetch stage: fetch PC, memory handshake, prefetch FIFO
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   im_req, im_addr   : fetch request and word-aligned address to instruction memory
//   im_ack            : memory accepts request; im_data/im_err valid this cycle
//   im_data, im_err   : fetched word and bus error flag
//   id_halt           : decode not accepting this cycle
//   set_pc, new_pc    : redirect request and target
//   if_ins, if_pc     : head instruction (NOP_INS when empty) and its PC
//   if_valid, if_err  : FIFO non-empty, head entry carries a bus error
module core_if
    import core_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CORE_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INS    = CORE_NOP_INS
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    input  logic        im_err,
    input  logic        id_halt,
    input  logic        set_pc,
    input  logic [31:0] new_pc,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    if_state_t    state;
    if_state_t    state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  disc_addr;   // address of the abandoned in-flight request
    logic [31:0]  last_pc;     // if_pc shown while the FIFO is empty
    logic [CW-1:0] count;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    fetch_entry_t wentry;
    fetch_entry_t head;

    assign im_req  = ~rst & (((state == ST_FETCH) && (count < DEPTH_CNT)) || (state == ST_DISCARD));
    assign im_addr = (state == ST_DISCARD) ? disc_addr : fetch_pc;

    // A redirect flushes the FIFO, so any ack or pop in that cycle is void.
    // ~full is defensive: count cannot rise while a request is pending.
    assign push = (state == ST_FETCH) & im_req & im_ack & ~set_pc & ~full;
    assign pop  = ~empty & ~id_halt & ~set_pc;

    assign wentry = '{err: im_err, pc: im_addr, ins: im_data};

    core_if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (set_pc),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        if (set_pc) begin
            state_nxt = (im_req && !im_ack) ? ST_DISCARD : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:   if (push && im_err) state_nxt = ST_ERR;
                ST_DISCARD: if (im_ack) state_nxt = ST_FETCH;
                ST_ERR:     state_nxt = ST_ERR;
                default:    state_nxt = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FETCH;
            fetch_pc  <= {RESET_PC[31:2], 2'b00};
            disc_addr <= {RESET_PC[31:2], 2'b00};
            last_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (set_pc) begin
                fetch_pc <= {new_pc[31:2], 2'b00};
                // In DISCARD the old request is still outstanding; keep its address.
                if (state != ST_DISCARD) begin
                    disc_addr <= fetch_pc;
                end
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (!empty) begin
                last_pc <= head.pc;
            end
        end
    end

    assign if_valid = ~empty;
    assign if_ins   = empty ? NOP_INS : head.ins;
    assign if_pc    = empty ? last_pc : head.pc;
    assign if_err   = ~empty & head.err;

endmodule

// File: tb/tb_core_if.sv
// tb/tb_core_if.sv - directed self-checking bench for core_if
module tb_core_if;

    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_data;
    logic        im_err;
    logic        id_halt;
    logic        set_pc;
    logic [31:0] new_pc;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_err;

    int total;
    int bad;

    core_if #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2),
        .NOP_INS    (TB_NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_ack   (im_ack),
        .im_data  (im_data),
        .im_err   (im_err),
        .id_halt  (id_halt),
        .set_pc   (set_pc),
        .new_pc   (new_pc),
        .if_ins   (if_ins),
        .if_pc    (if_pc),
        .if_valid (if_valid),
        .if_err   (if_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; im_ack = 1'b0; im_err = 1'b0; id_halt = 1'b0;
        set_pc = 1'b0; new_pc = '0; im_data = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; im_ack = 1'b0; im_err = 1'b0; id_halt = 1'b0;
        set_pc = 1'b0; new_pc = '0; im_data = '0;
        tick();
        tick();
        total++; if (im_req !== 1'b0) begin bad++; $display("FAIL reset_im_req got=%b exp=0", im_req); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        total++; if (if_ins !== TB_NOP) begin bad++; $display("FAIL reset_if_ins got=%h exp=%h", if_ins, TB_NOP); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        total++; if (if_err !== 1'b0) begin bad++; $display("FAIL reset_if_err got=%b exp=0", if_err); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            total++; if (im_req !== 1'b1) begin bad++; $display("FAIL stream_req k=%0d got=%b exp=1", k, im_req); end
            total++; if (im_addr !== 32'(k * 4)) begin bad++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, im_addr, 32'(k * 4)); end
            if (k == 0) begin
                total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_first_valid got=%b exp=0", if_valid); end
            end else begin
                total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, if_valid); end
                total++; if (if_pc !== 32'((k - 1) * 4)) begin bad++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, if_pc, 32'((k - 1) * 4)); end
                total++; if (if_ins !== data_of(32'((k - 1) * 4))) begin bad++; $display("FAIL stream_ins k=%0d got=%h exp=%h", k, if_ins, data_of(32'((k - 1) * 4))); end
            end
            im_ack = 1'b1; im_data = data_of(32'(k * 4)); id_halt = 1'b0;
            tick();
        end
        im_ack = 1'b0;
    endtask

    task automatic test_halt();
        do_reset();
        id_halt = 1'b1; im_ack = 1'b1; im_data = data_of(32'h0);
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL halt_first got_valid=%b got_pc=%h exp=1/0", if_valid, if_pc); end
        total++; if (im_req !== 1'b1 || im_addr !== 32'h4) begin bad++; $display("FAIL halt_req4 got_req=%b got_addr=%h exp=1/4", im_req, im_addr); end
        im_data = data_of(32'h4);
        tick();
        im_ack = 1'b0;
        total++; if (im_req !== 1'b0 || im_addr !== 32'h8) begin bad++; $display("FAIL halt_full_req got_req=%b got_addr=%h exp=0/8", im_req, im_addr); end
        tick();
        tick();
        total++; if (im_req !== 1'b0 || if_pc !== 32'h0) begin bad++; $display("FAIL halt_hold got_req=%b got_pc=%h exp=0/0", im_req, if_pc); end
        id_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4)) begin bad++; $display("FAIL halt_drain i=%0d got_valid=%b got_pc=%h exp=1/%h", i, if_valid, if_pc, 32'(i * 4)); end
            im_ack = im_req; im_data = data_of(im_addr);
            tick();
        end
        im_ack = 1'b0;
    endtask

    task automatic test_delay();
        do_reset();
        im_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (im_req !== 1'b1 || im_addr !== 32'h0 || if_valid !== 1'b0) begin
                bad++; $display("FAIL delay_wait i=%0d got_req=%b got_addr=%h got_valid=%b exp=1/0/0", i, im_req, im_addr, if_valid);
            end
            tick();
        end
        im_ack = 1'b1; im_data = data_of(32'h0);
        tick();
        im_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_ins !== data_of(32'h0)) begin
            bad++; $display("FAIL delay_out got_valid=%b got_pc=%h got_ins=%h exp=1/0/%h", if_valid, if_pc, if_ins, data_of(32'h0));
        end
    endtask

    task automatic test_redirect();
        do_reset();
        im_ack = 1'b1; im_data = data_of(32'h0); tick();
        im_data = data_of(32'h4); tick();
        total++; if (im_req !== 1'b1 || im_addr !== 32'h8) begin bad++; $display("FAIL redir_pending got_req=%b got_addr=%h exp=1/8", im_req, im_addr); end
        im_ack = 1'b0; set_pc = 1'b1; new_pc = 32'h100;
        tick();
        set_pc = 1'b0;
        total++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h8) begin
            bad++; $display("FAIL redir_discard got_valid=%b got_req=%b got_addr=%h exp=0/1/8", if_valid, im_req, im_addr);
        end
        im_ack = 1'b1; im_data = data_of(32'h8);
        tick();
        im_ack = 1'b0;
        total++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h100) begin
            bad++; $display("FAIL redir_dropped got_valid=%b got_req=%b got_addr=%h exp=0/1/100", if_valid, im_req, im_addr);
        end
        im_ack = 1'b1; im_data = data_of(32'h100);
        tick();
        im_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_ins !== data_of(32'h100)) begin
            bad++; $display("FAIL redir_target got_valid=%b got_pc=%h got_ins=%h exp=1/100/%h", if_valid, if_pc, if_ins, data_of(32'h100));
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        im_ack = 1'b1; im_data = data_of(32'h0); tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || im_addr !== 32'h4) begin
            bad++; $display("FAIL same_pre got_valid=%b got_pc=%h got_addr=%h exp=1/0/4", if_valid, if_pc, im_addr);
        end
        im_ack = 1'b1; im_data = data_of(32'h4); id_halt = 1'b0; set_pc = 1'b1; new_pc = 32'h302;
        tick();
        set_pc = 1'b0; im_ack = 1'b0;
        total++; if (if_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h300) begin
            bad++; $display("FAIL same_flush got_valid=%b got_req=%b got_addr=%h exp=0/1/300", if_valid, im_req, im_addr);
        end
        im_ack = 1'b1; im_data = data_of(32'h300);
        tick();
        im_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h300) begin bad++; $display("FAIL same_target got_valid=%b got_pc=%h exp=1/300", if_valid, if_pc); end
    endtask

    task automatic test_err();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            im_ack = 1'b1; im_data = data_of(32'(k * 4)); im_err = (k == 4);
            tick();
        end
        im_ack = 1'b0; im_err = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_err !== 1'b1 || im_req !== 1'b0) begin
            bad++; $display("FAIL err_entry got_valid=%b got_pc=%h got_err=%b got_req=%b exp=1/10/1/0", if_valid, if_pc, if_err, im_req);
        end
        id_halt = 1'b1;
        tick();
        tick();
        total++; if (im_req !== 1'b0 || if_pc !== 32'h10 || if_err !== 1'b1) begin
            bad++; $display("FAIL err_hold got_req=%b got_pc=%h got_err=%b exp=0/10/1", im_req, if_pc, if_err);
        end
        id_halt = 1'b0;
        tick();
        total++; if (if_valid !== 1'b0 || if_err !== 1'b0 || if_ins !== TB_NOP || im_req !== 1'b0 || if_pc !== 32'h10) begin
            bad++; $display("FAIL err_empty got_valid=%b got_err=%b got_ins=%h got_req=%b got_pc=%h exp=0/0/%h/0/10",
                            if_valid, if_err, if_ins, im_req, if_pc, TB_NOP);
        end
        set_pc = 1'b1; new_pc = 32'h200;
        tick();
        set_pc = 1'b0;
        total++; if (im_req !== 1'b1 || im_addr !== 32'h200) begin bad++; $display("FAIL err_resume got_req=%b got_addr=%h exp=1/200", im_req, im_addr); end
        im_ack = 1'b1; im_data = data_of(32'h200);
        tick();
        im_ack = 1'b0;
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_err !== 1'b0) begin
            bad++; $display("FAIL err_after got_valid=%b got_pc=%h got_err=%b exp=1/200/0", if_valid, if_pc, if_err);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; im_ack = 1'b0; im_data = '0; im_err = 1'b0;
        id_halt = 1'b0; set_pc = 1'b0; new_pc = '0;
        test_reset();
        test_stream();
        test_halt();
        test_delay();
        test_redirect();
        test_same_cycle();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_if.md
Name: core_if

Overview:
- Instruction fetch stage of the i2d core. It sits directly upstream of instruction decode and drives if_ins/if_pc into it.
- Owns the fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO so decode stalls (id_halt) do not stall the memory port.
- Handles redirects (set_pc) and fetch bus errors.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
FIFO_DEPTH, 2, prefetch entries (power of two, >=2)
NOP_INS, 32'h0000_0000, instruction word presented when FIFO empty

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
im_req  out  1  fetch request to instruction memory
im_addr  out  32  word-aligned fetch address
im_ack  in  1  memory accepts request; im_data/im_err valid this cycle
im_data  in  32  fetched instruction word
im_err  in  1  bus error for this fetch
id_halt  in  1  decode not accepting this cycle
set_pc  in  1  redirect request (branch/call/exception)
new_pc  in  32  redirect target
if_ins  out  32  head-of-FIFO instruction, NOP_INS when empty
if_pc  out  32  PC of if_ins
if_valid  out  1  FIFO non-empty
if_err  out  1  head entry carries fetch bus error

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc<=RESET_PC, FIFO count<=0, state<=FETCH.
  - Outputs: im_req=0 during reset, if_valid=0, if_ins=NOP_INS, if_pc=0, if_err=0.
- Handshake:
  - im_req=1 only in FETCH or DISCARD, and in FETCH only when count<FIFO_DEPTH.
  - Once raised, im_req and im_addr hold stable until im_ack.
  - Transfer completes in a cycle with im_req&im_ack.
  - Max one outstanding request; im_addr[1:0]=0 always.
- States:
  - FETCH: on im_ack, push {im_data, im_addr, im_err} and set fetch_pc<=fetch_pc+4 (wraps mod 2^32). If im_err, go to ERR.
  - DISCARD: a request is in flight when set_pc arrives. Keep im_req/im_addr at the old address until im_ack, drop the response, then go to FETCH with fetch_pc=redirect target.
  - ERR: im_req=0; hold FIFO contents. Leave only on set_pc.
- Latency and throughput:
  - First im_req is in the first cycle after rst deasserts, with im_addr=RESET_PC.
  - With zero-wait memory, ack in cycle N gives if_valid=1 in cycle N+1.
  - Sustained throughput is 1 instruction/cycle when id_halt=0.
- Pop: when if_valid & ~id_halt at posedge. Push and pop may occur in the same cycle; count is unchanged.
- Full FIFO (count==FIFO_DEPTH): no new request is raised. A request already raised cannot overflow, because count cannot rise while im_req is pending.
- Empty FIFO: if_valid=0, if_ins=NOP_INS, if_err=0, if_pc holds its last value.
- set_pc (highest priority):
  - Same posedge: count<=0, fetch_pc<=new_pc, no push or pop takes effect.
  - Any im_ack in that cycle is dropped.
  - If im_req was high without ack, go to DISCARD, else FETCH.
  - set_pc while in DISCARD updates the latched target and stays in DISCARD.
  - set_pc in ERR goes to FETCH.
  - new_pc[1:0] is ignored and forced to 0.
- rst mid-transaction: state returns to FETCH immediately and im_req drops; the memory must tolerate the abandoned request.

Decomposition:
- i2d_core_defines.v: CORE_IF_STATE_FETCH/DISCARD/ERR encodings, CORE_NOP_INS, CORE_RESET_PC.
- Sub-module core_if_fifo: synchronous FIFO with push, pop, flush, count, full and empty; 65-bit entries {err, pc, ins}; flush has priority over push and pop.

Test Plan:
- Reset release, zero-wait ack, id_halt=0 -> im_addr 0,4,8,... on consecutive cycles; if_pc 0,4,8 starting one cycle after the first ack; if_valid stays 1.
- Hold id_halt=1 from the first valid -> exactly 2 words buffered (pc 0,4); im_req drops with im_addr=8. Release id_halt -> outputs pc 0,4,8 in order with no duplicates.
- im_ack delayed 3 cycles -> im_addr stays constant and im_req stays high for all 3 cycles; if_valid=0 meanwhile.
- set_pc with new_pc=0x100 while a request to 0x8 is pending -> FIFO empties next cycle; the ack for 0x8 is dropped (if_pc never shows 0x8); next im_addr=0x100.
- set_pc in the same cycle as im_ack and a pop -> count=0 after the edge and the acked word is discarded; next fetch is to new_pc.
- im_err on fetch of 0x10 -> entry with if_pc=0x10 and if_err=1 reaches the output; im_req stays 0 until set_pc=0x200, then fetching resumes at 0x200.
